// File: rtl/call_return_stack_pkg.sv
// rtl/call_return_stack_pkg.sv - shared constants, checkpoint struct and helpers for the return stack
package call_return_stack_pkg;

  localparam int CRS_DEPTH    = 16;
  localparam int CRS_PTR_W    = 4;
  localparam int CRS_IP_WIDTH = 48;

  // Snapshot stored alongside each in-flight branch so a mispredict can repair the stack.
  typedef struct packed {
    logic [CRS_PTR_W-1:0]    ptr;
    logic [CRS_PTR_W:0]      cnt;
    logic [CRS_IP_WIDTH-1:0] top;
  } crs_ckpt_t;

  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/call_return_stack_if.sv
// rtl/call_return_stack_if.sv - decoder/recovery bus between the front end and the return stack
interface call_return_stack_if
  import call_return_stack_pkg::*;
#(
  parameter int PTR_W    = CRS_PTR_W,
  parameter int IP_WIDTH = CRS_IP_WIDTH
);

  logic                stall;
  logic                push;
  logic                pop;
  logic [IP_WIDTH-1:0] push_addr;
  logic [IP_WIDTH-1:0] ret_target;
  logic                ret_valid;
  logic                restore_en;
  logic [PTR_W-1:0]    restore_ptr;
  logic [PTR_W:0]      restore_cnt;
  logic [IP_WIDTH-1:0] restore_top;
  logic [PTR_W-1:0]    ckpt_ptr;
  logic [PTR_W:0]      ckpt_cnt;
  logic [IP_WIDTH-1:0] ckpt_top;
  logic [15:0]         overflow_cnt;
  logic [15:0]         underflow_cnt;

  modport master (
    output stall, push, pop, push_addr,
    output restore_en, restore_ptr, restore_cnt, restore_top,
    input  ret_target, ret_valid, ckpt_ptr, ckpt_cnt, ckpt_top,
    input  overflow_cnt, underflow_cnt
  );

  modport slave (
    input  stall, push, pop, push_addr,
    input  restore_en, restore_ptr, restore_cnt, restore_top,
    output ret_target, ret_valid, ckpt_ptr, ckpt_cnt, ckpt_top,
    output overflow_cnt, underflow_cnt
  );

endinterface

// File: rtl/call_return_stack_crs_mem.sv
// rtl/call_return_stack_crs_mem.sv - return-address register file, one async read and one write port
module crs_mem #(
  parameter int DEPTH    = 16,
  parameter int PTR_W    = 4,
  parameter int IP_WIDTH = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wrEn,
  input  logic [PTR_W-1:0]    wrAddr,
  input  logic [IP_WIDTH-1:0] wrData,
  input  logic [PTR_W-1:0]    rdAddr,
  output logic [IP_WIDTH-1:0] rdData
);

  logic [IP_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/call_return_stack.sv
// rtl/call_return_stack.sv - circular return-address stack with checkpoint export and mispredict restore
module call_return_stack
  import call_return_stack_pkg::*;
#(
  parameter int DEPTH    = CRS_DEPTH,
  parameter int PTR_W    = CRS_PTR_W,
  parameter int IP_WIDTH = CRS_IP_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  call_return_stack_if.slave   bus
);

  localparam logic [PTR_W:0]   DepthCnt = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PtrOne   = PTR_W'(1);
  localparam logic [PTR_W:0]   CntOne   = (PTR_W+1)'(1);

  logic [PTR_W-1:0]    ptr, nextPtr;
  logic [PTR_W:0]      cnt, nextCnt;
  logic [15:0]         overflowCnt, underflowCnt;
  logic                incOverflow, incUnderflow;
  logic                wrEn;
  logic [PTR_W-1:0]    wrAddr;
  logic [IP_WIDTH-1:0] wrData;
  logic [IP_WIDTH-1:0] topEntry;

  crs_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W), .IP_WIDTH(IP_WIDTH)) uMem (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .wrData (wrData),
    .rdAddr (ptr),
    .rdData (topEntry)
  );

  always_comb begin
    nextPtr      = ptr;
    nextCnt      = cnt;
    wrEn         = 1'b0;
    wrAddr       = ptr;
    wrData       = bus.push_addr;
    incOverflow  = 1'b0;
    incUnderflow = 1'b0;
    if (bus.restore_en) begin
      // An out-of-range checkpointed count is clamped rather than trusted.
      nextPtr = bus.restore_ptr;
      nextCnt = (bus.restore_cnt > DepthCnt) ? DepthCnt : bus.restore_cnt;
      wrEn    = 1'b1;
      wrAddr  = bus.restore_ptr;
      wrData  = bus.restore_top;
    end else if (!bus.stall) begin
      unique case ({bus.push, bus.pop})
        2'b10: begin
          nextPtr = ptr + PtrOne;
          wrEn    = 1'b1;
          wrAddr  = ptr + PtrOne;
          if (cnt == DepthCnt) incOverflow = 1'b1;
          else                 nextCnt     = cnt + CntOne;
        end
        2'b01: begin
          if (cnt != '0) begin
            nextPtr = ptr - PtrOne;
            nextCnt = cnt - CntOne;
          end else begin
            incUnderflow = 1'b1;
          end
        end
        // Simultaneous call and return replaces the top in place.
        2'b11: begin
          wrEn   = 1'b1;
          wrAddr = ptr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr          <= '0;
      cnt          <= '0;
      overflowCnt  <= '0;
      underflowCnt <= '0;
    end else begin
      ptr <= nextPtr;
      cnt <= nextCnt;
      if (incOverflow)  overflowCnt  <= satInc16(overflowCnt);
      if (incUnderflow) underflowCnt <= satInc16(underflowCnt);
    end
  end

  assign bus.ret_target    = topEntry;
  assign bus.ret_valid     = (cnt != '0);
  assign bus.ckpt_ptr      = ptr;
  assign bus.ckpt_cnt      = cnt;
  assign bus.ckpt_top      = topEntry;
  assign bus.overflow_cnt  = overflowCnt;
  assign bus.underflow_cnt = underflowCnt;

endmodule
